// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the pipelined multiplier.
package mul_pkg;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_mode_e;

  // Digit width D = ceil((width + 1) / (stages - 1)): the multiplier operand,
  // extended by one sign bit, is split into stages-1 digits of D bits.
  function automatic int unsigned digit_width(int unsigned width, int unsigned stages);
    return (width + stages - 1) / (stages - 1);
  endfunction

  // Bit width of one pipeline stage record:
  // {valid, mode, tag, a_ext, b_ext, acc}.
  function automatic int unsigned stage_bits(int unsigned width, int unsigned stages,
                                             int unsigned tag_w);
    return 2 + tag_w + (width + 1) + (stages - 1) * digit_width(width, stages) + 2 * width;
  endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// One accumulate stage: adds digit (IDX-1) of b times the extended a,
// shifted into place, onto the running accumulator. Holds while en is low.
module mul_pp_stage
  import mul_pkg::*;
#(
  parameter int unsigned IDX   = 1,
  parameter int unsigned WIDTH = 35,
  parameter int unsigned D     = 8,
  parameter int unsigned NDIG  = 5,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned BW    = NDIG * D,
  localparam int unsigned ACC_W = 2 * WIDTH,
  localparam int unsigned SW    = 2 + TAG_W + (WIDTH + 1) + BW + ACC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [SW-1:0] prev,
  output logic [SW-1:0] curr
);

  typedef struct packed {
    logic             valid;
    mul_mode_e        mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH:0]   a_ext;
    logic [BW-1:0]    b_ext;
    logic [ACC_W-1:0] acc;
  } stage_t;

  localparam int unsigned SH     = (IDX - 1) * D;
  localparam logic        IS_TOP = (IDX == NDIG);

  stage_t                   p;
  stage_t                   q;
  stage_t                   nxt;
  logic [D-1:0]             digit;
  logic                     dig_neg;
  logic signed [D:0]        dig_s;
  logic signed [WIDTH:0]    a_s;
  logic signed [ACC_W-1:0]  prod;

  assign p       = prev;
  assign digit   = p.b_ext[SH +: D];
  // Only the most significant digit carries negative weight, and only in signed mode.
  assign dig_neg = IS_TOP && (p.mode == MUL_SIGNED) && digit[D-1];
  assign dig_s   = {dig_neg, digit};
  assign a_s     = p.a_ext;
  // Arithmetic is modulo 2^ACC_W, so the truncated signed product is exact.
  assign prod    = ACC_W'(a_s) * ACC_W'(dig_s);

  // Pass the record through, accumulating this stage's partial product.
  always_comb begin
    nxt     = p;
    nxt.acc = p.acc + (prod << SH);
  end

  // Stage register: cleared on reset, frozen whenever the pipe is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

  assign curr = q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined WIDTH x WIDTH multiplier with valid/ready handshake,
// per-operation signed/unsigned mode and a sideband tag.
module pipelined_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 35,
  parameter int unsigned STAGES = 6,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned D     = digit_width(WIDTH, STAGES);
  localparam int unsigned NDIG  = STAGES - 1;
  localparam int unsigned BW    = NDIG * D;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef struct packed {
    logic             valid;
    mul_mode_e        mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH:0]   a_ext;
    logic [BW-1:0]    b_ext;
    logic [ACC_W-1:0] acc;
  } stage_t;

  stage_t s0;
  stage_t s0_nxt;
  stage_t stg [STAGES];
  logic   adv;
  logic   sa;
  logic   sb;

  // One global advance enable: the whole pipe moves unless a finished
  // result is waiting for the consumer.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign sa = in_signed & in_a[WIDTH-1];
  assign sb = in_signed & in_b[WIDTH-1];

  // Stage 0 operand capture: extend a by one bit and b to the full digit span.
  always_comb begin
    s0_nxt       = '0;
    s0_nxt.valid = in_valid;
    s0_nxt.mode  = in_signed ? MUL_SIGNED : MUL_UNSIGNED;
    s0_nxt.tag   = in_tag;
    s0_nxt.a_ext = {sa, in_a};
    s0_nxt.b_ext = {{(BW - WIDTH){sb}}, in_b};
    s0_nxt.acc   = '0;
  end

  // Input register; holds together with the rest of the pipe on a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= '0;
    end else if (adv) begin
      s0 <= s0_nxt;
    end
  end

  assign stg[0] = s0;

  // The last accumulate stage doubles as the output register, which keeps
  // the register count (and so the latency) equal to STAGES.
  for (genvar k = 1; k < STAGES; k++) begin : g_pp
    mul_pp_stage #(
      .IDX   (k),
      .WIDTH (WIDTH),
      .D     (D),
      .NDIG  (NDIG),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (adv),
      .prev  (stg[k-1]),
      .curr  (stg[k])
    );
  end

  assign out_valid = stg[STAGES-1].valid;
  assign out_prod  = stg[STAGES-1].acc;
  assign out_tag   = stg[STAGES-1].tag;

  logic unused_tail;
  assign unused_tail = ^{stg[STAGES-1].mode, stg[STAGES-1].a_ext, stg[STAGES-1].b_ext};

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench for pipelined_multiplier (WIDTH=35, STAGES=6, TAG_W=4).
module tb_pipelined_multiplier;

  localparam int unsigned W  = 35;
  localparam int unsigned S  = 6;
  localparam int unsigned TW = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prod;
  logic [TW-1:0] out_tag;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct packed {
    logic [PW-1:0] prod;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  pipelined_multiplier #(
    .WIDTH  (W),
    .STAGES (S),
    .TAG_W  (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  // Reference product: extend both operands to PW+2 bits and truncate.
  function automatic logic [PW-1:0] ref_mul(logic s, logic [W-1:0] a, logic [W-1:0] b);
    logic signed [PW+1:0] xa;
    logic signed [PW+1:0] xb;
    logic signed [PW+1:0] p;
    xa = s ? {{(PW + 2 - W){a[W-1]}}, a} : {{(PW + 2 - W){1'b0}}, a};
    xb = s ? {{(PW + 2 - W){b[W-1]}}, b} : {{(PW + 2 - W){1'b0}}, b};
    p  = xa * xb;
    return p[PW-1:0];
  endfunction

  // Scoreboard: push on accept, pop and compare on drain (both judged at the
  // negedge for the upcoming rising edge). Reset discards in-flight entries.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_unexpected: got prod=%h tag=%h, required no result", out_prod, out_tag);
        end else begin
          e = sbq.pop_front();
          if (out_prod !== e.prod || out_tag !== e.tag) begin
            bad++;
            $display("FAIL scoreboard: got prod=%h tag=%h, required prod=%h tag=%h",
                     out_prod, out_tag, e.prod, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{prod: ref_mul(in_signed, in_a, in_b), tag: in_tag});
      end
    end
  end

  // Present one operation until accepted (called just after a rising edge).
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t);
    logic done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got in_ready=0 for 50 cycles, required accept");
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    total++;
    if (out_prod !== '0) begin
      bad++; $display("FAIL reset_out_prod: got %h, required 0", out_prod);
    end
    total++;
    if (out_tag !== '0) begin
      bad++; $display("FAIL reset_out_tag: got %h, required 0", out_tag);
    end
  endtask

  task automatic test_directed();
    logic          ts [7];
    logic [W-1:0]  ta [7];
    logic [W-1:0]  tb [7];
    logic [TW-1:0] tt [7];
    logic [PW-1:0] te [7];
    int unsigned   lat;
    ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ta = '{35'h4_0000_0000, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF,
           35'h4_0000_0000, 35'h0, 35'h3_FFFF_FFFF};
    tb = '{35'h2, 35'h7_FFFF_FFFF, 35'h5, 35'h7_FFFF_FFFF,
           35'h4_0000_0000, 35'h7_FFFF_FFFF, 35'h4_0000_0000};
    tt = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    te = '{70'h0_0000_0008_0000_0000, 70'h3F_FFFF_FFF0_0000_0001,
           70'h3F_FFFF_FFFF_FFFF_FFFB, 70'h0_0000_0000_0000_0001,
           70'h10_0000_0000_0000_0000, 70'h0,
           70'h30_0000_0004_0000_0000};
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      issue(ts[i], ta[i], tb[i], tt[i]);
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      total++;
      if (lat != S) begin
        bad++; $display("FAIL directed%0d_latency: got %0d cycles, required %0d", i, lat, S);
      end
      total++;
      if (out_prod !== te[i] || out_tag !== tt[i]) begin
        bad++;
        $display("FAIL directed%0d_result: got prod=%h tag=%h, required prod=%h tag=%h",
                 i, out_prod, out_tag, te[i], tt[i]);
      end
      @(posedge clk);
      #1;
    end
    drain("directed");
  endtask

  task automatic test_back_to_back();
    int unsigned first;
    int unsigned seen;
    first     = 0;
    seen      = 0;
    out_ready = 1'b1;
    for (int unsigned c = 1; c <= 30; c++) begin
      if (c <= 20) begin
        in_valid  = 1'b1;
        in_signed = 1'($urandom_range(0, 1));
        in_a      = W'({$urandom, $urandom});
        in_b      = W'({$urandom, $urandom});
        in_tag    = TW'(c - 1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen++;
        if (first == 0) first = c;
      end
    end
    in_valid = 1'b0;
    total++;
    if (first != S) begin
      bad++; $display("FAIL b2b_first: got first result at cycle %0d, required %0d", first, S);
    end
    total++;
    if (seen != 20) begin
      bad++; $display("FAIL b2b_throughput: got %0d result cycles, required 20", seen);
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] hold_p;
    logic [TW-1:0] hold_t;
    logic          acc;
    int unsigned   n;
    n         = 0;
    hold_p    = '0;
    hold_t    = '0;
    in_signed = 1'($urandom_range(0, 1));
    in_a      = W'({$urandom, $urandom});
    in_b      = W'({$urandom, $urandom});
    in_tag    = TW'($urandom);
    for (int unsigned c = 1; c <= 24; c++) begin
      out_ready = !(c >= 10 && c <= 13);
      in_valid  = (n < 16);
      #1;
      if (c >= 10 && c <= 13) begin
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL bp_stall%0d: got in_ready=%b out_valid=%b, required 0/1", c, in_ready, out_valid);
        end
      end
      if (c == 10) begin
        hold_p = out_prod;
        hold_t = out_tag;
      end
      if (c >= 11 && c <= 14) begin
        total++;
        if (out_prod !== hold_p || out_tag !== hold_t) begin
          bad++;
          $display("FAIL bp_stable%0d: got prod=%h tag=%h, required prod=%h tag=%h",
                   c, out_prod, out_tag, hold_p, hold_t);
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n++;
        in_signed = 1'($urandom_range(0, 1));
        in_a      = W'({$urandom, $urandom});
        in_b      = W'({$urandom, $urandom});
        in_tag    = TW'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (n != 16) begin
      bad++; $display("FAIL bp_accepts: got %0d accepted, required 16", n);
    end
    drain("bp");
  endtask

  task automatic test_reset_flush();
    int unsigned seen;
    int unsigned lat;
    seen      = 0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_signed = 1'b0;
      in_a      = W'(i + 11);
      in_b      = W'(i + 7);
      in_tag    = TW'(i + 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_out_valid: got %b, required 0", out_valid);
    end
    for (int unsigned c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL flush_ghost: got %0d result cycles, required 0", seen);
    end
    issue(1'b1, 35'h7_FFFF_FFFD, 35'h3, 4'hC);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat != S || out_prod !== 70'h3F_FFFF_FFFF_FFFF_FFF7 || out_tag !== 4'hC) begin
      bad++;
      $display("FAIL flush_new_op: got lat=%0d prod=%h tag=%h, required lat=%0d prod=3ffffffffffffffff7 tag=c",
               lat, out_prod, out_tag, S);
    end
    drain("flush");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
